// File: rtl/sync_pkg.sv
// Shared types, default timing constants and the round-robin search used by
// the detector trigger scheduler and other shared-resource arbiters.
package sync_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FIRE     = 2'd1,
        WAIT_RDY = 2'd2
    } state_t;

    localparam int PULSE_CYCLES_DEF  = 32'd20;
    localparam int GUARD_CYCLES_DEF  = 32'd200;
    localparam int READY_TIMEOUT_DEF = 32'd40000;
    localparam int MAX_REQ           = 32'd8;

    typedef struct packed {
        logic       valid;
        logic [2:0] id;
    } rr_result_t;

    // First set bit at or above ptr, wrapping modulo n_req.
    function automatic rr_result_t rr_pick(input logic [MAX_REQ-1:0] pend,
                                           input logic [2:0]         ptr,
                                           input int                 n_req);
        rr_result_t res;
        int         idx;
        res.valid = 1'b0;
        res.id    = 3'd0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= n_req) begin
                idx = idx - n_req;
            end else begin
                idx = idx;
            end
            if ((k < n_req) && !res.valid && pend[idx[2:0]]) begin
                res.valid = 1'b1;
                res.id    = idx[2:0];
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner selection over a pending vector.
module rr_arbiter
    import sync_pkg::*;
#(
    parameter int N_REQ = 32'd4
) (
    input  logic [N_REQ-1:0]         pending,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic                     win_valid,
    output logic [$clog2(N_REQ)-1:0] win_id
);

    rr_result_t w_res;

    assign w_res     = rr_pick(MAX_REQ'(pending), 3'(ptr), N_REQ);
    assign win_valid = w_res.valid;
    assign win_id    = ($clog2(N_REQ))'(w_res.id);

endmodule

// File: rtl/trigger_scheduler.sv
// Shares one detector trigger line between N_REQ requesters: round-robin
// grants inside a settled fast-gate window, then a busy hold until ready/timeout.
module trigger_scheduler
    import sync_pkg::*;
#(
    parameter int N_REQ         = 32'd4,
    parameter int PULSE_CYCLES  = PULSE_CYCLES_DEF,
    parameter int GUARD_CYCLES  = GUARD_CYCLES_DEF,
    parameter int READY_TIMEOUT = READY_TIMEOUT_DEF,
    parameter int CNT_W         = 32'd16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [N_REQ-1:0]         req,
    input  logic                     fg_signal,
    input  logic                     detector_ready,
    input  logic                     clear,
    output logic                     output_trigger,
    output logic                     grant_valid,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic [N_REQ-1:0]         pending,
    output logic                     timeout_flag,
    output logic [7:0]               overflow_count
);

    localparam int ID_W = $clog2(N_REQ);

    logic             r_fg_meta, r_fg_s;
    logic             r_rdy_meta, r_rdy_s, r_rdy_d;
    logic [CNT_W-1:0] r_guard, r_cnt;
    logic [N_REQ-1:0] r_pending;
    logic [7:0]       r_ovf;
    logic             r_timeout, r_trig, r_busy, r_grant_valid;
    logic [ID_W-1:0]  r_ptr, r_grant_id;
    state_t           r_state;

    logic             w_gate_ok, w_rdy_rise, w_win_valid, w_grant, w_timeout_hit;
    logic [ID_W-1:0]  w_win_id, w_ptr_nxt;
    logic [N_REQ-1:0] w_grant_mask;
    logic [3:0]       w_drop_cnt;
    logic [8:0]       w_ovf_sum;
    logic [CNT_W-1:0] w_cnt_nxt;
    state_t           w_state_nxt;

    assign w_gate_ok  = r_fg_s && (r_guard == CNT_W'(GUARD_CYCLES));
    assign w_rdy_rise = r_rdy_s && !r_rdy_d;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .pending   (r_pending),
        .ptr       (r_ptr),
        .win_valid (w_win_valid),
        .win_id    (w_win_id)
    );

    assign w_grant_mask = w_grant ? (N_REQ'(1'b1) << w_win_id) : {N_REQ{1'b0}};
    assign w_ptr_nxt    = (w_win_id == ID_W'(N_REQ - 32'd1)) ? {ID_W{1'b0}}
                                                             : w_win_id + ID_W'(1'b1);

    // Next-state and counter logic; the pulse always runs to completion.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_grant       = 1'b0;
        w_timeout_hit = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable && w_gate_ok && w_win_valid) begin
                    w_state_nxt = FIRE;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                    w_grant     = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            FIRE: begin
                if (r_cnt == CNT_W'(PULSE_CYCLES - 32'd1)) begin
                    w_state_nxt = WAIT_RDY;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1'b1);
                end
            end
            WAIT_RDY: begin
                if (w_rdy_rise) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end else if (r_cnt == CNT_W'(READY_TIMEOUT - 32'd1)) begin
                    w_state_nxt   = IDLE;
                    w_cnt_nxt     = {CNT_W{1'b0}};
                    w_timeout_hit = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1'b1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Requests dropped because that requester is still waiting (not the one being served).
    always_comb begin
        w_drop_cnt = 4'd0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req[i] && r_pending[i] && !w_grant_mask[i]) begin
                w_drop_cnt = w_drop_cnt + 4'd1;
            end else begin
                w_drop_cnt = w_drop_cnt;
            end
        end
        w_ovf_sum = {1'b0, r_ovf} + {5'd0, w_drop_cnt};
    end

    // Input synchronizers and fast-gate guard counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_fg_meta  <= 1'b0;
            r_fg_s     <= 1'b0;
            r_rdy_meta <= 1'b0;
            r_rdy_s    <= 1'b0;
            r_rdy_d    <= 1'b0;
            r_guard    <= {CNT_W{1'b0}};
        end else begin
            r_fg_meta  <= fg_signal;
            r_fg_s     <= r_fg_meta;
            r_rdy_meta <= detector_ready;
            r_rdy_s    <= r_rdy_meta;
            r_rdy_d    <= r_rdy_s;
            if (!r_fg_s) begin
                r_guard <= {CNT_W{1'b0}};
            end else if (r_guard != CNT_W'(GUARD_CYCLES)) begin
                r_guard <= r_guard + CNT_W'(1'b1);
            end else begin
                r_guard <= r_guard;
            end
        end
    end

    // Pending latch, overflow counter and sticky timeout flag (timeout beats clear).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= {N_REQ{1'b0}};
            r_ovf     <= 8'd0;
            r_timeout <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_grant_mask) | req;
            if (clear) begin
                r_ovf <= 8'd0;
            end else if (w_ovf_sum > 9'd255) begin
                r_ovf <= 8'd255;
            end else begin
                r_ovf <= w_ovf_sum[7:0];
            end
            if (w_timeout_hit) begin
                r_timeout <= 1'b1;
            end else if (clear) begin
                r_timeout <= 1'b0;
            end else begin
                r_timeout <= r_timeout;
            end
        end
    end

    // FSM state, grant bookkeeping and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_cnt         <= {CNT_W{1'b0}};
            r_trig        <= 1'b0;
            r_busy        <= 1'b0;
            r_grant_valid <= 1'b0;
            r_grant_id    <= {ID_W{1'b0}};
            r_ptr         <= {ID_W{1'b0}};
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_trig        <= (w_state_nxt == FIRE);
            r_busy        <= (w_state_nxt != IDLE);
            r_grant_valid <= w_grant;
            if (w_grant) begin
                r_grant_id <= w_win_id;
                r_ptr      <= w_ptr_nxt;
            end else begin
                r_grant_id <= r_grant_id;
                r_ptr      <= r_ptr;
            end
        end
    end

    assign output_trigger = r_trig;
    assign grant_valid    = r_grant_valid;
    assign grant_id       = r_grant_id;
    assign busy           = r_busy;
    assign pending        = r_pending;
    assign timeout_flag   = r_timeout;
    assign overflow_count = r_ovf;

endmodule
